// File: rtl/ls280_serial_parity_rx.sv
// Serial parity receiver: deserialises DATA_BITS data bits (LSB first) plus one
// parity bit, then presents the word with a one-cycle strobe and a parity-error flag.
module ls280_serial_parity_rx #(
   parameter int DATA_BITS  = 8,
   parameter int ODD_PARITY = 0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 SIN,
   input  logic                 SVALID,
   input  logic                 SSTART,
   output logic [DATA_BITS-1:0] DOUT,
   output logic                 DVALID,
   output logic                 PERR,
   output logic                 ABORT,
   output logic                 BUSY
);

   localparam int   CW     = $clog2(DATA_BITS + 1);
   localparam logic LP_ODD = (ODD_PARITY != 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic [CW-1:0]        r_cnt,   w_cnt_nxt;
   logic                 r_acc,   w_acc_nxt;
   logic [DATA_BITS-1:0] r_dout,  w_dout_nxt;
   logic                 r_perr,  w_perr_nxt;
   logic                 r_dvalid, w_dvalid_nxt;
   logic                 r_abort,  w_abort_nxt;
   logic                 r_busy,   w_busy_nxt;

   // Error when the XOR over data and parity disagrees with the selected sense.
   function automatic logic f_parity_err(input logic acc, input logic sin);
      return acc ^ sin ^ LP_ODD;
   endfunction

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath decode; SSTART restarts from any state.
   always_comb begin
      w_state_nxt  = r_state;
      w_shift_nxt  = r_shift;
      w_cnt_nxt    = r_cnt;
      w_acc_nxt    = r_acc;
      w_dout_nxt   = r_dout;
      w_perr_nxt   = r_perr;
      w_dvalid_nxt = 1'b0;
      w_abort_nxt  = 1'b0;
      if (SVALID) begin
         if (SSTART) begin
            w_abort_nxt    = (r_state != S_IDLE);
            w_shift_nxt    = '0;
            w_shift_nxt[0] = SIN;
            w_cnt_nxt      = CW'(1);
            w_acc_nxt      = SIN;
            w_state_nxt    = S_DATA;
         end else begin
            case (r_state)
               S_IDLE: begin
                  w_state_nxt = S_IDLE;
               end
               S_DATA: begin
                  for (int i = 0; i < DATA_BITS; i++) begin
                     if (r_cnt == CW'(i)) begin
                        w_shift_nxt[i] = SIN;
                     end else begin
                        w_shift_nxt[i] = r_shift[i];
                     end
                  end
                  w_acc_nxt = r_acc ^ SIN;
                  w_cnt_nxt = r_cnt + CW'(1);
                  if (r_cnt == CW'(DATA_BITS - 1)) begin
                     w_state_nxt = S_PARITY;
                  end else begin
                     w_state_nxt = S_DATA;
                  end
               end
               S_PARITY: begin
                  w_dout_nxt   = r_shift;
                  w_perr_nxt   = f_parity_err(r_acc, SIN);
                  w_dvalid_nxt = 1'b1;
                  w_cnt_nxt    = '0;
                  w_state_nxt  = S_IDLE;
               end
               default: begin
                  w_state_nxt = S_IDLE;
               end
            endcase
         end
      end else begin
         w_state_nxt = r_state;
      end
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // Datapath and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_shift  <= '0;
         r_cnt    <= '0;
         r_acc    <= 1'b0;
         r_dout   <= '0;
         r_perr   <= 1'b0;
         r_dvalid <= 1'b0;
         r_abort  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_shift  <= w_shift_nxt;
         r_cnt    <= w_cnt_nxt;
         r_acc    <= w_acc_nxt;
         r_dout   <= w_dout_nxt;
         r_perr   <= w_perr_nxt;
         r_dvalid <= w_dvalid_nxt;
         r_abort  <= w_abort_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign DOUT   = r_dout;
   assign PERR   = r_perr;
   assign DVALID = r_dvalid;
   assign ABORT  = r_abort;
   assign BUSY   = r_busy;

endmodule
